// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of i_sig_in over GATE clocks.
// Define FREQ_METER_PERIOD_EN to also measure clocks between the first two rises.
module freq_meter #(
    parameter int GATE = 1_000_000,
    parameter int CW   = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_sig_in,
    output logic          o_busy,
    output logic          o_done,
    output logic [CW-1:0] o_count,
    output logic          o_overflow,
    output logic [CW-1:0] o_period
);

    localparam int GW = (GATE > 1) ? $clog2(GATE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic          w_rise;

    logic [GW-1:0] r_gate_cnt;
    logic [CW-1:0] r_edge_cnt;
    logic          r_ovf_acc;
    logic          w_last_gate;
    logic          w_finish;
    logic [CW-1:0] w_edge_next;
    logic          w_ovf_next;

    logic [CW-1:0] r_count;
    logic          r_overflow;

    // Synchronizer runs in every state so no stale edge appears on entry to MEASURE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise      = r_s2 & ~r_s3;
    assign w_last_gate = (r_gate_cnt == GW'(GATE - 1));
    assign w_finish    = (r_state == S_MEASURE) && w_last_gate;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_next = S_ARM;
            S_ARM:     w_state_next = S_MEASURE;
            S_MEASURE: if (w_last_gate) w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);

    // An edge on the final gate cycle must reach the outputs, so results load from these.
    always_comb begin
        w_edge_next = r_edge_cnt;
        w_ovf_next  = r_ovf_acc;
        if (w_rise) begin
            if (&r_edge_cnt) begin
                w_ovf_next = 1'b1;
            end else begin
                w_edge_next = r_edge_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_acc  <= 1'b0;
        end else begin
            case (r_state)
                S_ARM: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_ovf_acc  <= 1'b0;
                end
                S_MEASURE: begin
                    if (!w_last_gate) begin
                        r_gate_cnt <= r_gate_cnt + GW'(1);
                    end
                    r_edge_cnt <= w_edge_next;
                    r_ovf_acc  <= w_ovf_next;
                end
                default: begin
                    r_gate_cnt <= r_gate_cnt;
                    r_edge_cnt <= r_edge_cnt;
                    r_ovf_acc  <= r_ovf_acc;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_finish) begin
            r_count    <= w_edge_next;
            r_overflow <= w_ovf_next;
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

`ifdef FREQ_METER_PERIOD_EN
    logic [1:0]    r_rise_seen;
    logic [CW-1:0] r_period_cnt;
    logic [1:0]    w_seen_next;
    logic [CW-1:0] w_pcnt_next;
    logic [CW-1:0] r_period;

    // r_rise_seen: 0 = waiting for first rise, 1 = timing, 2 = second rise seen (frozen).
    always_comb begin
        w_seen_next = r_rise_seen;
        w_pcnt_next = r_period_cnt;
        case (r_rise_seen)
            2'd0: begin
                if (w_rise) begin
                    w_seen_next = 2'd1;
                    w_pcnt_next = '0;
                end
            end
            2'd1: begin
                if (!(&r_period_cnt)) begin
                    w_pcnt_next = r_period_cnt + CW'(1);
                end
                if (w_rise) begin
                    w_seen_next = 2'd2;
                end
            end
            default: begin
                w_seen_next = r_rise_seen;
                w_pcnt_next = r_period_cnt;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rise_seen  <= 2'd0;
            r_period_cnt <= '0;
        end else if (r_state == S_ARM) begin
            r_rise_seen  <= 2'd0;
            r_period_cnt <= '0;
        end else if (r_state == S_MEASURE) begin
            r_rise_seen  <= w_seen_next;
            r_period_cnt <= w_pcnt_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_period <= '0;
        end else if (w_finish) begin
            r_period <= (w_seen_next == 2'd2) ? w_pcnt_next : '0;
        end
    end

    assign o_period = r_period;
`else
    assign o_period = '0;
`endif

endmodule
